// File: rtl/seqdet_pkg.sv
// Shared types for the serial pattern detector: controller FSM states and reset pattern.
package seqdet_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic [3:0] PAT_RESET_DEF = 4'b0101;

endpackage

// File: rtl/seq_hist_match.sv
// Bit history shift register with a valid-bit counter and length-masked pattern compare.
// match is combinational on the bit being consumed this cycle (history including bit_in).
module seq_hist_match #(
  parameter int PAT_W = 4,
  parameter int LEN_W = $clog2(PAT_W + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             bit_vld,
  input  logic             bit_in,
  input  logic [PAT_W-1:0] pattern,
  input  logic [LEN_W-1:0] len,
  input  logic             clear,
  output logic             match
);

  logic [PAT_W-1:0] hist;
  logic [PAT_W-1:0] hist_nxt;
  logic [PAT_W-1:0] mask;
  logic [PAT_W-1:0] ones;
  logic [LEN_W-1:0] vcnt;
  logic             cnt_ok;

  always_comb begin
    ones     = '1;
    hist_nxt = {hist[PAT_W-2:0], bit_in};
    mask     = ~(ones << len);
    // the incoming bit itself counts towards the required history depth
    cnt_ok   = (({1'b0, vcnt} + (LEN_W+1)'(1)) >= {1'b0, len});
    match    = bit_vld && cnt_ok && ((hist_nxt & mask) == (pattern & mask));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hist <= '0;
      vcnt <= '0;
    end else if (clear) begin
      hist <= '0;
      vcnt <= '0;
    end else if (bit_vld) begin
      hist <= hist_nxt;
      if (vcnt != LEN_W'(PAT_W)) vcnt <= vcnt + LEN_W'(1);
    end
  end

endmodule

// File: rtl/seq_stream_ctrl.sv
// Word-to-bit stream controller feeding seq_hist_match; one word per WORD_W+2 cycles, saturating hit count.
// Define SEQDET_IRQ_EN to add irq_thresh/irq (sticky threshold interrupt, cleared by count_clr).
module seq_stream_ctrl
  import seqdet_pkg::*;
#(
  parameter int              WORD_W    = 8,
  parameter int              PAT_W     = 4,
  parameter int              CNT_W     = 16,
  parameter logic [PAT_W-1:0] PAT_RESET = PAT_W'(PAT_RESET_DEF)
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         cfg_load,
  input  logic [PAT_W-1:0]             cfg_pattern,
  input  logic [$clog2(PAT_W+1)-1:0]   cfg_len,
  input  logic                         in_valid,
  input  logic [WORD_W-1:0]            in_data,
  output logic                         in_ready,
  input  logic                         count_clr,
  output logic                         hit,
  output logic [$clog2(WORD_W)-1:0]    hit_pos,
  output logic                         word_done,
  output logic                         busy,
  output logic [CNT_W-1:0]             hit_count
`ifdef SEQDET_IRQ_EN
  ,
  input  logic [CNT_W-1:0]             irq_thresh,
  output logic                         irq
`endif
);

  localparam int LEN_W = $clog2(PAT_W + 1);
  localparam int IDX_W = $clog2(WORD_W);

  state_t             state;
  state_t             state_nxt;
  logic [WORD_W-1:0]  word_sr;
  logic [IDX_W-1:0]   bit_idx;
  logic [PAT_W-1:0]   pat_q;
  logic [LEN_W-1:0]   len_q;
  logic [LEN_W-1:0]   len_norm;
  logic               accept;
  logic               cfg_take;
  logic               shift_vld;
  logic               last_bit;
  logic               match;

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    busy      = 1'b1;
    word_done = 1'b0;
    shift_vld = 1'b0;
    unique case (state)
      ST_IDLE: begin
        busy     = 1'b0;
        in_ready = !cfg_load;
        if (in_valid && !cfg_load) state_nxt = ST_SHIFT;
      end
      ST_SHIFT: begin
        shift_vld = 1'b1;
        if (last_bit) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        word_done = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign accept   = in_valid && in_ready;
  assign cfg_take = cfg_load && (state == ST_IDLE);
  assign last_bit = (bit_idx == IDX_W'(WORD_W - 1));

  // ---------------- word serializer ----------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      word_sr <= '0;
      bit_idx <= '0;
    end else if (accept) begin
      word_sr <= in_data;
      bit_idx <= '0;
    end else if (shift_vld) begin
      word_sr <= {word_sr[WORD_W-2:0], 1'b0};
      bit_idx <= bit_idx + IDX_W'(1);
    end
  end

  // ---------------- pattern configuration ----------------
  always_comb begin
    len_norm = cfg_len;
    if (cfg_len == '0 || cfg_len > LEN_W'(PAT_W)) len_norm = LEN_W'(PAT_W);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pat_q <= PAT_RESET;
      len_q <= LEN_W'(PAT_W);
    end else if (cfg_take) begin
      pat_q <= cfg_pattern;
      len_q <= len_norm;
    end
  end

  seq_hist_match #(
    .PAT_W (PAT_W),
    .LEN_W (LEN_W)
  ) u_match (
    .clk     (clk),
    .reset_n (reset_n),
    .bit_vld (shift_vld),
    .bit_in  (word_sr[WORD_W-1]),
    .pattern (pat_q),
    .len     (len_q),
    .clear   (cfg_take),
    .match   (match)
  );

  // ---------------- hit reporting and count ----------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hit     <= 1'b0;
      hit_pos <= '0;
    end else begin
      hit <= match;
      if (match) hit_pos <= bit_idx;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                       hit_count <= '0;
    else if (count_clr)                 hit_count <= '0;
    else if (hit && (hit_count != '1))  hit_count <= hit_count + CNT_W'(1);
  end

`ifdef SEQDET_IRQ_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                                            irq <= 1'b0;
    else if (count_clr)                                      irq <= 1'b0;
    else if ((irq_thresh != '0) && (hit_count >= irq_thresh)) irq <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_seq_stream_ctrl.sv
// Bench for seq_stream_ctrl: directed scenarios plus random traffic against a queue-based reference model.
module tb_seq_stream_ctrl;

  localparam int WORD_W = 8;
  localparam int PAT_W  = 4;
  localparam int CNT_W  = 3;
  localparam int LEN_W  = $clog2(PAT_W + 1);
  localparam int POS_W  = $clog2(WORD_W);
  localparam int CMAX   = (1 << CNT_W) - 1;
  localparam int MAXC   = 8192;
  localparam logic [PAT_W-1:0] PAT_RST = 4'b0101;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              cfg_load = 1'b0;
  logic [PAT_W-1:0]  cfg_pattern = '0;
  logic [LEN_W-1:0]  cfg_len = '0;
  logic              in_valid = 1'b0;
  logic [WORD_W-1:0] in_data = '0;
  logic              count_clr = 1'b0;
  logic              in_ready, hit, word_done, busy;
  logic [POS_W-1:0]  hit_pos;
  logic [CNT_W-1:0]  hit_count;
`ifdef SEQDET_IRQ_EN
  logic [CNT_W-1:0]  irq_thresh = '0;
  logic              irq;
`endif

  always #5 clk = ~clk;

  seq_stream_ctrl #(
    .WORD_W(WORD_W), .PAT_W(PAT_W), .CNT_W(CNT_W), .PAT_RESET(PAT_RST)
  ) dut (
    .clk(clk), .reset_n(reset_n), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .count_clr(count_clr), .hit(hit), .hit_pos(hit_pos), .word_done(word_done),
    .busy(busy), .hit_count(hit_count)
`ifdef SEQDET_IRQ_EN
    , .irq_thresh(irq_thresh), .irq(irq)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // expected per-cycle outputs, filled in when a word is accepted
  bit exp_hit [MAXC];
  bit exp_done[MAXC];
  bit exp_busy[MAXC];
  int exp_pos [MAXC];

  bit               hist[$];
  logic [PAT_W-1:0] m_pat;
  int               m_len;
  int               m_cnt;
  bit               m_irq;
  bit               m_idle;
  int               last_t;

  int seen_pos[$];
  int seen_hit_cyc[$];
  int seen_done_cyc[$];
  int irq_rise = -1;

  task automatic chk(string name, int act, int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d actual=%0d expected=%0d", name, cyc, act, exp);
    end
  endtask

  function automatic bit model_match();
    if (hist.size() < m_len) return 1'b0;
    for (int i = 0; i < m_len; i++)
      if (hist[hist.size() - 1 - i] != m_pat[i]) return 1'b0;
    return 1'b1;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // reference model
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = cyc; i < MAXC; i++) begin
        exp_hit[i] = 1'b0; exp_done[i] = 1'b0; exp_busy[i] = 1'b0;
      end
      hist.delete();
      m_pat = PAT_RST; m_len = PAT_W; m_cnt = 0; m_irq = 1'b0;
    end else begin
      m_idle = !exp_busy[cyc];
`ifdef SEQDET_IRQ_EN
      if (count_clr) m_irq = 1'b0;
      else if (irq_thresh != 0 && m_cnt >= int'(irq_thresh)) m_irq = 1'b1;
`endif
      if (count_clr) m_cnt = 0;
      else if (exp_hit[cyc] && m_cnt < CMAX) m_cnt++;
      if (m_idle && cfg_load) begin
        m_pat = cfg_pattern;
        m_len = (cfg_len == 0 || cfg_len > PAT_W) ? PAT_W : int'(cfg_len);
        hist.delete();
      end else if (m_idle && in_valid) begin
        last_t = cyc;
        for (int k = 0; k < WORD_W; k++) begin
          hist.push_back(in_data[WORD_W-1-k]);
          if (hist.size() > PAT_W) void'(hist.pop_front());
          if (model_match()) begin
            exp_hit[cyc+2+k] = 1'b1;
            exp_pos[cyc+2+k] = k;
          end
        end
        for (int i = 1; i <= WORD_W + 1; i++) exp_busy[cyc+i] = 1'b1;
        exp_done[cyc+WORD_W+1] = 1'b1;
      end
    end
  end

  // per-cycle compare, mid-cycle
  always @(negedge clk) begin
    chk("in_ready", in_ready, int'(!exp_busy[cyc] && !cfg_load));
    chk("busy", busy, exp_busy[cyc]);
    chk("hit", hit, exp_hit[cyc]);
    chk("word_done", word_done, exp_done[cyc]);
    chk("hit_count", hit_count, m_cnt);
    if (exp_hit[cyc]) chk("hit_pos", hit_pos, exp_pos[cyc]);
`ifdef SEQDET_IRQ_EN
    chk("irq", irq, m_irq);
    if (irq && irq_rise < 0) irq_rise = cyc;
`endif
    if (hit) begin seen_pos.push_back(hit_pos); seen_hit_cyc.push_back(cyc); end
    if (word_done) seen_done_cyc.push_back(cyc);
  end

  task automatic tick(int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic clear_seen();
    seen_pos.delete(); seen_hit_cyc.delete(); seen_done_cyc.delete();
  endtask

  task automatic send_word(logic [WORD_W-1:0] d);
    bit got = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (in_ready) begin got = 1'b1; break; end
    end
    if (!got) begin
      n_tests++; n_fail++;
      $display("FAIL handshake_timeout cyc=%0d in_ready never rose", cyc);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic do_cfg(logic [PAT_W-1:0] p, logic [LEN_W-1:0] l);
    cfg_pattern = p; cfg_len = l; cfg_load = 1'b1;
    tick(1);
    cfg_load = 1'b0;
  endtask

  initial begin
    int t1;
    reset_n = 1'b0;
    tick(3);
    reset_n = 1'b1;

    // idle after reset
    tick(5);
    chk("t1_ready", in_ready, 1);
    chk("t1_busy", busy, 0);
    chk("t1_count", hit_count, 0);
    chk("t1_pulses", seen_pos.size() + seen_done_cyc.size(), 0);

    // default pattern 0101 on 0x55
    clear_seen();
    send_word(8'h55);
    tick(WORD_W + 2);
    chk("t2_nhits", seen_pos.size(), 3);
    if (seen_pos.size() == 3) begin
      chk("t2_pos0", seen_pos[0], 3);
      chk("t2_pos1", seen_pos[1], 5);
      chk("t2_pos2", seen_pos[2], 7);
      chk("t2_hit_lat", seen_hit_cyc[0] - last_t, 5);
    end
    chk("t2_count", hit_count, 3);
    chk("t2_ndone", seen_done_cyc.size(), 1);
    if (seen_done_cyc.size() == 1) chk("t2_done_lat", seen_done_cyc[0] - last_t, WORD_W + 1);

    // match spanning a word boundary, words back-to-back
    do_cfg(4'b0101, 3'd4);
    clear_seen();
    send_word(8'h01);
    t1 = last_t;
    send_word(8'h40);
    tick(WORD_W + 2);
    chk("t3_spacing", last_t - t1, WORD_W + 2);
    chk("t3_nhits", seen_pos.size(), 1);
    if (seen_pos.size() == 1) begin
      chk("t3_pos", seen_pos[0], 1);
      chk("t3_hit_cyc", seen_hit_cyc[0] - last_t, 3);
    end

    // pattern 111 len 3 on 0xFF
    count_clr = 1'b1; tick(1); count_clr = 1'b0;
    do_cfg(4'b0111, 3'd3);
    clear_seen();
    send_word(8'hFF);
    tick(WORD_W + 2);
    chk("t4_nhits", seen_pos.size(), 6);
    if (seen_pos.size() == 6)
      for (int i = 0; i < 6; i++) chk("t4_pos", seen_pos[i], i + 2);
    chk("t4_count", hit_count, 6);

    // cfg_load during SHIFT must be ignored
    clear_seen();
    send_word(8'h00);
    cfg_pattern = 4'b0000; cfg_len = 3'd1; cfg_load = 1'b1;
    tick(2);
    cfg_load = 1'b0;
    tick(WORD_W);
    chk("t4_ignored_hits", seen_pos.size(), 0);
    chk("t4_ignored_count", hit_count, 6);

    // saturation then count_clr coinciding with a hit
    send_word(8'hFF);
    tick(WORD_W + 2);
    chk("t5_sat", hit_count, CMAX);
    send_word(8'hFF);
    tick(3);
    count_clr = 1'b1; tick(1); count_clr = 1'b0;
    chk("t5_clr_wins", hit_count, 0);
    tick(5);
    chk("t5_after_clr", hit_count, 5);

    // reset in the middle of a word
    tick(3);
    clear_seen();
    send_word(8'h55);
    tick(3);
    reset_n = 1'b0;
    tick(2);
    reset_n = 1'b1;
    tick(WORD_W + 4);
    chk("t6_no_done", seen_done_cyc.size(), 0);
    chk("t6_no_hit", seen_pos.size(), 0);
    chk("t6_busy", busy, 0);

`ifdef SEQDET_IRQ_EN
    irq_thresh = 3'd2;
    irq_rise = -1;
    clear_seen();
    send_word(8'h55);
    tick(WORD_W + 3);
    chk("t6_irq", irq, 1);
    if (seen_hit_cyc.size() >= 2) chk("t6_irq_cyc", irq_rise - seen_hit_cyc[1], 2);
    count_clr = 1'b1; tick(1); count_clr = 1'b0;
    chk("t6_irq_clr", irq, 0);
`endif

    // random traffic
    for (int i = 0; i < 2500; i++) begin
      in_valid    = ($urandom_range(0, 3) != 0);
      in_data     = WORD_W'($urandom);
      cfg_load    = ($urandom_range(0, 15) == 0);
      cfg_pattern = PAT_W'($urandom_range(0, (1 << PAT_W) - 1));
      cfg_len     = LEN_W'($urandom_range(0, (1 << LEN_W) - 1));
      count_clr   = ($urandom_range(0, 40) == 0);
`ifdef SEQDET_IRQ_EN
      if ($urandom_range(0, 100) == 0) irq_thresh = CNT_W'($urandom_range(0, CMAX));
`endif
      tick(1);
    end
    in_valid = 1'b0; cfg_load = 1'b0; count_clr = 1'b0;
    tick(WORD_W + 4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
